mouse_receive: RTL and testbench
================================

MOUSE_RECEIVE -- requirements
Module: mouse_receive

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of CLK cycles the synchronized PS2CLK must hold a new level before that level is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: CLK cycles (2 ms at 50 MHz) allowed between accepted PS2CLK falling edges within a frame.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports: CLK  in  1  system clock, 50 MHz.
REQ-004 SHALL have port RST  in  1  asynchronous active-high reset.
REQ-005 SHALL have port PS2CLK  in  1  device-driven PS/2 clock, asynchronous to CLK.
REQ-006 SHALL have port PS2DATA  in  1  device-driven PS/2 data, asynchronous to CLK.
REQ-007 SHALL have port rx_en  in  1  receive enable; held low by the host while its transmitter owns the bus.
REQ-008 SHALL have port rx_data  out  8  last correctly received byte.
REQ-009 SHALL have port rx_done  out  1  one-cycle pulse when a good byte is presented on rx_data.
REQ-010 SHALL have port rx_err  out  1  one-cycle pulse on a parity, stop-bit or timeout failure.
REQ-011 SHALL have port rx_idle  out  1  high when no frame is in progress.

Function
REQ-012 SHALL pass PS2CLK and PS2DATA through two-flop synchronizers, then filter PS2CLK so that a level change is accepted only after FILTER_LEN consecutive identical samples.
REQ-013 SHALL sample synchronized PS2DATA on the CLK cycle in which a filtered PS2CLK falling edge is detected.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0; if data=1, stay in IDLE and flag nothing.
REQ-016 DATA: shift in 8 bits LSB first, one per falling edge; after the 8th bit, go to PARITY.
REQ-017 PARITY: capture the parity bit; go to STOP.
REQ-018 STOP: capture the stop bit and return to IDLE; if stop=1 and data+parity ones-count is odd, load rx_data and pulse rx_done; otherwise pulse rx_err and leave rx_data unchanged.
REQ-019 rx_done and rx_err SHALL be registered, asserted for exactly one cycle, and never asserted together.
REQ-020 rx_done SHALL occur 1 CLK after the CLK cycle that samples the stop bit.
REQ-021 The timeout counter SHALL clear on every accepted falling edge; if it reaches TIMEOUT_CYC while not in IDLE, the block SHALL pulse rx_err and return to IDLE.
REQ-022 Deasserting rx_en SHALL return the FSM to IDLE within 1 cycle, discard the partial frame and pulse neither rx_done nor rx_err.
REQ-023 While rx_en=0, falling edges SHALL be ignored.
REQ-024 rx_idle SHALL equal 1 exactly when the state is IDLE.

Reset
REQ-025 On RST=1 the block SHALL asynchronously go to IDLE, with rx_data=8'h00, rx_done=0, rx_err=0, rx_idle=1, bit and timeout counters=0, and synchronizer and filter flops=1 (idle bus level).
REQ-026 RST asserted mid-frame SHALL abort the frame, with no rx_done or rx_err pulse after release.

Structure
REQ-027 Shared package ps2_pkg SHALL hold the state enumeration, frame length (11), the mouse ACK constant 8'hFA, and the default FILTER_LEN and TIMEOUT_CYC values.
REQ-028 The synchronizer and glitch filter SHALL be a sub-module ps2_clk_filter, which outputs a filtered level and a one-cycle falling-edge strobe.

Verification (bench: TIMEOUT_CYC=2000, PS2 clock period 10 us, data changes mid-high phase)
REQ-029 RST 100 ns then release, rx_en=1, device sends 8'hFA with parity 1 and stop 1 -> exactly one rx_done, rx_data=8'hFA, no rx_err, rx_idle returns to 1.
REQ-030 Device sends 8'h08, 8'h01, 8'hFF back-to-back -> three rx_done pulses, with rx_data 8'h08, 8'h01, 8'hFF in order.
REQ-031 Device sends 8'hAA with parity 0 (wrong) -> one rx_err, no rx_done, rx_data keeps its previous value.
REQ-032 Device sends 8'h55 with correct parity and stop=0 -> one rx_err, no rx_done.
REQ-033 Device stops clocking after 4 data bits -> rx_err 2000 cycles after the last edge, rx_idle=1, and the next full 8'hF4 frame is received correctly.
REQ-034 20 ns PS2CLK low glitches while idle -> no state change; rx_en dropped after bit 3 -> no pulses, rx_idle=1 within 1 cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 receive constants, state codes, frame check.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package ps2_pkg;

  localparam int         FRAME_LEN       = 11;
  localparam int         DATA_BITS       = FRAME_LEN - 3;
  localparam logic [7:0] MOUSE_ACK       = 8'hFA;
  localparam int         FILTER_LEN_DEF  = 8;
  localparam int         TIMEOUT_CYC_DEF = 100000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DATA   = 2'd1;
  localparam state_t ST_PARITY = 2'd2;
  localparam state_t ST_STOP   = 2'd3;

  // A byte is good when the stop bit is high and data plus parity carry odd ones.
  function automatic logic frame_ok(input logic [DATA_BITS-1:0] data,
                                    input logic parity, input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_clk_filter : 2-flop sync of PS2CLK/PS2DATA, PS2CLK glitch filter.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2clk_i,
  input  logic ps2data_i,
  output logic clk_filt_o,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2clk_i};
      data_sync_q <= {data_sync_q[0], ps2data_i};
      fall_q      <= 1'b0;
      if (clk_sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // FILTER_LEN-th consecutive differing sample: accept the new level
        filt_q <= clk_sync_q[1];
        fall_q <= ~clk_sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign clk_filt_o = filt_q;
  assign fall_o     = fall_q;
  assign data_o     = data_sync_q[1];

endmodule
`default_nettype wire

// File: rtl/mouse_receive.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mouse_receive : PS/2 device-to-host byte receiver with timeout.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mouse_receive
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2CLK,
  input  logic       PS2DATA,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       rx_idle
);

  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
  localparam int            BW      = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 clk_filt;
  logic                 fall;
  logic                 data_s;

  state_t               state_q,  state_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 parity_q, parity_d;
  logic [TW-1:0]        tmo_q,    tmo_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 done_q,   done_d;
  logic                 err_q,    err_d;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_i      (CLK),
    .rst_i      (RST),
    .ps2clk_i   (PS2CLK),
    .ps2data_i  (PS2DATA),
    .clk_filt_o (clk_filt),
    .fall_o     (fall),
    .data_o     (data_s)
  );

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (!rx_en) begin
      // Host owns the bus: drop any partial frame silently.
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      tmo_d    = '0;
    end else if (state_q != ST_IDLE && !fall && tmo_q == TMO_MAX) begin
      err_d    = 1'b1;
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      tmo_d    = '0;
    end else begin
      if (fall || state_q == ST_IDLE) tmo_d = '0;
      else                            tmo_d = tmo_q + TW'(1);

      case (state_q)
        ST_IDLE: begin
          if (fall && !data_s) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shift_d  = {data_s, shift_q[DATA_BITS-1:1]};
            bitcnt_d = bitcnt_q + BW'(1);
            if (bitcnt_q == BIT_LAST) state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (fall) begin
            parity_d = data_s;
            state_d  = ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            if (frame_ok(shift_q, parity_q, data_s)) begin
              rx_data_d = shift_q;
              done_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      rx_data_q <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_done = done_q;
  assign rx_err  = err_q;
  assign rx_idle = (state_q == ST_IDLE);

  logic unused_filt;
  assign unused_filt = clk_filt;

endmodule
`default_nettype wire

// File: tb/tb_mouse_receive.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mouse_receive : scoreboard bench for mouse_receive.                |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mouse_receive;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       rx_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       rx_idle;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         errors = 0;
  longint     last_fall_t = 0;
  bit         prev_pulse = 1'b0;

  always #10 clk = ~clk;

  mouse_receive #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (2000)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .PS2CLK  (ps2clk),
    .PS2DATA (ps2data),
    .rx_en   (rx_en),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_err  (rx_err),
    .rx_idle (rx_idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic expect_done(input logic [7:0] d);
    exp_q.push_back('{1'b0, d});
    last_good = d;
  endtask

  task automatic expect_err();
    exp_q.push_back('{1'b1, last_good});
  endtask

  // 10 us PS/2 clock, data updated in the middle of the high phase.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2data = f[i];
      #2500;
      ps2clk = 1'b0;
      last_fall_t = $time;
      #5000;
      ps2clk = 1'b1;
      #2500;
    end
    ps2data = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_done || rx_err) begin
        chk("done_err_exclusive", {31'd0, rx_done & rx_err}, 32'd0);
        chk("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b data=%0h, expected no pulse (t=%0t)",
                   rx_done, rx_err, rx_data, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_err", {31'd0, rx_err}, {31'd0, e.is_err});
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        end
      end
      prev_pulse = rx_done | rx_err;
    end
  end

  initial begin
    logic [10:0] f;
    bit          got;
    longint      cyc;

    #50;
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_rx_err",  {31'd0, rx_err},  32'd0);
    chk("reset_rx_idle", {31'd0, rx_idle}, 32'd1);
    #50;
    rst   = 1'b0;
    rx_en = 1'b1;
    #1000;

    // ACK byte, with a mid-frame idle check
    expect_done(MOUSE_ACK);
    f = mk(MOUSE_ACK, 1'b1, 1'b1);
    send_bits(f, 5);
    chk("idle_midframe", {31'd0, rx_idle}, 32'd0);
    send_bits(f >> 5, 6);
    chk("idle_after_ack", {31'd0, rx_idle}, 32'd1);

    // back-to-back bytes
    expect_done(8'h08); send_bits(mk(8'h08, 1'b0, 1'b1), 11);
    expect_done(8'h01); send_bits(mk(8'h01, 1'b0, 1'b1), 11);
    expect_done(8'hFF); send_bits(mk(8'hFF, 1'b1, 1'b1), 11);

    // bad parity, then bad stop bit
    expect_err(); send_bits(mk(8'hAA, 1'b0, 1'b1), 11);
    expect_err(); send_bits(mk(8'h55, 1'b1, 1'b0), 11);
    chk("idle_after_errs", {31'd0, rx_idle}, 32'd1);

    // timeout after start + 4 data bits
    expect_err();
    send_bits(mk(8'hF4, 1'b0, 1'b1), 5);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (rx_err) got = 1'b1;
    end
    chk("timeout_seen", {31'd0, got}, 32'd1);
    cyc = ($time - last_fall_t) / 20;
    chk("timeout_latency_in_window", {31'd0, (cyc >= 2000 && cyc <= 2040)}, 32'd1);
    #1;
    chk("idle_after_timeout", {31'd0, rx_idle}, 32'd1);
    expect_done(8'hF4); send_bits(mk(8'hF4, 1'b0, 1'b1), 11);

    // short low glitches with data low must not start a frame
    ps2data = 1'b0;
    for (int g = 0; g < 3; g++) begin
      #1000;
      ps2clk = 1'b0;
      #20;
      ps2clk = 1'b1;
    end
    #1000;
    chk("idle_after_glitch", {31'd0, rx_idle}, 32'd1);
    ps2data = 1'b1;
    #2500;
    expect_done(8'h12); send_bits(mk(8'h12, 1'b1, 1'b1), 11);

    // receive enable dropped after data bit 3
    f = mk(8'hC3, 1'b1, 1'b1);
    send_bits(f, 4);
    chk("idle_before_drop", {31'd0, rx_idle}, 32'd0);
    @(negedge clk);
    rx_en = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_1cyc_after_drop", {31'd0, rx_idle}, 32'd1);
    send_bits(f >> 4, 3);
    chk("idle_while_disabled", {31'd0, rx_idle}, 32'd1);
    rx_en = 1'b1;
    #5000;
    chk("idle_after_reenable", {31'd0, rx_idle}, 32'd1);

    // reset in the middle of a frame
    send_bits(mk(8'h77, 1'b0, 1'b1), 6);
    rst = 1'b1;
    #100;
    chk("midframe_rst_data", {24'd0, rx_data}, 32'd0);
    chk("midframe_rst_idle", {31'd0, rx_idle}, 32'd1);
    rst = 1'b0;
    last_good = 8'h00;
    #50000;
    expect_done(8'h3C); send_bits(mk(8'h3C, 1'b1, 1'b1), 11);

    #20000;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
